// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types for the MEM-stage SRAM controller: FSM state encoding,
// SRAM data width, access opcode, and byte-address to word-index helper.
package arm_mem_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_LO_ENC   = 2'd1;
    localparam logic [1:0] ST_HI_ENC   = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        LO   = ST_LO_ENC,
        HI   = ST_HI_ENC,
        DONE = ST_DONE_ENC
    } state_t;

    localparam int SRAM_DQ_W = 16;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Word index of a byte address relative to the SRAM window base
    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Requester-side bundle between the EXE/MEM register and the controller.
// master: pipeline (drives rd_en/wr_en/addr/wr_data); slave: controller.
interface sram_mem_ctrl_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, addr, wr_data,
        input  rd_data, ready
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data,
        output rd_data, ready
    );

endinterface

// File: rtl/sram_mem_ctrl_phase.sv
// sram_phase_timer: counts cycles within one SRAM half-word phase.
// Ports: clk, rst (sync, high), start (clear on phase entry), last, near_last.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic last,
    output logic near_last
);

    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] PEN  = CW'(WAIT_CYCLES - 2);

    logic [CW-1:0] cnt;

    // Saturates at TERM outside a phase; start re-arms it at the entry edge
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (cnt != TERM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last      = (cnt == TERM);
    // Next cycle is the last one: write strobe must rise now for hold time
    assign near_last = (cnt == PEN);

endmodule

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases.
// Ports: clk, rst (sync, high), req (slave bundle), sram_* async SRAM pins.
// Option: define SRAM_CTRL_POSTED_WRITE_EN to release the pipeline on write accept.
module sram_mem_ctrl
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_ctrl_if.slave       req,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [SRAM_DQ_W-1:0] sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0] sram_dq_in,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    state_t                state;
    op_t                   op;
    logic [ADDR_W-2:0]     word_q;
    logic [31:0]           wdata_q;
    logic [SRAM_DQ_W-1:0]  lo_buf;
    logic [31:0]           rd_data_q;
    logic                  we_n_q;

    logic        any_req;
    op_t         acc_op;
    logic [31:0] word_in;
    logic        start;
    logic        last;
    logic        near_last;
    logic        posted_ok;

    assign any_req = req.rd_en | req.wr_en;
    // Simultaneous rd_en/wr_en resolves to a read
    assign acc_op  = req.rd_en ? OP_RD : OP_WR;
    assign word_in = word_index(req.addr, 32'(BASE_ADDR));
    assign start   = ((state == IDLE) && any_req) || ((state == LO) && last);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    assign posted_ok = req.wr_en & ~req.rd_en;
`else
    assign posted_ok = 1'b0;
`endif

    assign req.ready = (state == DONE)
                     || ((state == IDLE) && (!any_req || posted_ok));
    assign req.rd_data = rd_data_q;

    // Reset must never start or extend a write pulse
    assign sram_we_n = we_n_q | rst;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last      (last),
        .near_last (near_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_RD;
            word_q      <= '0;
            wdata_q     <= '0;
            lo_buf      <= '0;
            rd_data_q   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            we_n_q      <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= LO;
                        op        <= acc_op;
                        word_q    <= (ADDR_W-1)'(word_in);
                        wdata_q   <= req.wr_data;
                        sram_addr <= {(ADDR_W-1)'(word_in), 1'b0};
                        if (acc_op == OP_WR) begin
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= req.wr_data[15:0];
                            we_n_q      <= 1'b0;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (last) begin
                        state     <= HI;
                        sram_addr <= {word_q, 1'b1};
                        if (op == OP_WR) begin
                            sram_dq_out <= wdata_q[31:16];
                            we_n_q      <= 1'b0;
                        end else begin
                            lo_buf <= sram_dq_in;
                        end
                    end else if (near_last) begin
                        we_n_q <= 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        // Posted writes already released the pipeline
                        state      <= (op == OP_WR && posted_ok_q()) ? IDLE : DONE;
                        we_n_q     <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (op == OP_RD) begin
                            rd_data_q <= {sram_dq_in, lo_buf};
                        end
                    end else if (near_last) begin
                        we_n_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    function automatic logic posted_ok_q();
`ifdef SRAM_CTRL_POSTED_WRITE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: random loads/stores against a word-level
// reference memory, with a behavioural async SRAM on the pins.
module tb_sram_mem_ctrl;

    localparam int AW   = 18;
    localparam int W    = 2;
    localparam int BASE = 1024;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic [63:0] wm;
        logic [63:0] om;
        logic [63:0] dm;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;
    logic          sram_oe_n;

    sram_mem_ctrl_if bus ();

    sram_mem_ctrl #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Behavioural SRAM: write committed while we_n is low mid-cycle
    logic [15:0] sram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
        forever begin
            @(negedge clk);
            if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_out;
        end
    end
    assign sram_dq_in = !sram_oe_n ? sram[sram_addr] : 16'hDEAD;

    // Reference: 32-bit words keyed by half-address-space word index
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd = 32'h0;
    exp_t        expq [$];

    function automatic int unsigned key_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) / 4;
        return w % (1 << (AW - 1));
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return 32'h0;
    endfunction

    task automatic issue(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int unsigned k;
        bit got;
        k = key_of(a);
        e.wm = '0; e.om = '0; e.dm = '0;
        e.lat = 2 * W + 1;
        if (rd) begin
            e.rd = ref_get(k);
            last_rd = e.rd;
            for (int i = 1; i <= 2 * W; i++) e.om[i] = 1'b1;
        end else begin
            ref_mem[k] = d;
            e.rd = last_rd;
            for (int i = 1; i <= 2 * W; i++) e.dm[i] = 1'b1;
            for (int p = 0; p < 2; p++)
                for (int c = 0; c < W - 1; c++) e.wm[1 + p * W + c] = 1'b1;
        end
        expq.push_back(e);
        bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wr_data = d;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.ready) got = 1;
        end
        if (!got) chk("drv_wait_ready", 32'h0, 32'h1);
        @(posedge clk); #1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    // Monitor: per-transaction strobe traces, compared when ready closes it
    logic        trk = 1'b0;
    int          t;
    logic [63:0] wm, om, dm;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            trk = 1'b0;
        end else begin
            if (!trk && (bus.rd_en || bus.wr_en)) begin
                trk = 1'b1; t = 0; wm = '0; om = '0; dm = '0;
            end
            if (trk) begin
                wm[t] = !sram_we_n;
                om[t] = !sram_oe_n;
                dm[t] = sram_dq_oe;
                if (bus.ready || t >= 40) begin
                    trk = 1'b0;
                    if (expq.size() == 0) begin
                        chk("unexpected_completion", 32'h1, 32'h0);
                    end else begin
                        e = expq.pop_front();
                        chk("rd_data", bus.rd_data, e.rd);
`ifndef SRAM_CTRL_POSTED_WRITE_EN
                        chk("latency", t, e.lat);
                        chk("we_n_trace", wm[31:0], e.wm[31:0]);
                        chk("oe_n_trace", om[31:0], e.om[31:0]);
                        chk("dq_oe_trace", dm[31:0], e.dm[31:0]);
`endif
                    end
                end
                t++;
            end
        end
    end

    logic [31:0] old;

    initial begin
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus.addr = 32'h0; bus.wr_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 16'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 32'd1024, 32'h12345678);
        chk("w1_half0", sram[0], 16'h5678);
        chk("w1_half1", sram[1], 16'h1234);
        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        issue(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        issue(1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF);
        // Upper word-index bits alias onto half 0/1 of the SRAM
        issue(1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'hA5A5_5A5A);
        issue(1'b1, 1'b0, 32'd1024, 32'h0);

        // Reset during first HI cycle of a write
        repeat (3) @(posedge clk); #1;
        old = ref_get(0);
        bus.wr_en = 1'b1; bus.addr = 32'd1024; bus.wr_data = 32'hAAAA_BBBB;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1; bus.wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_dq_oe", sram_dq_oe, 1'b0);
        chk("abort_rd_data", bus.rd_data, 32'h0);
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_half0", sram[0], 16'hBBBB);
        chk("abort_half1", sram[1], old[31:16]);
        ref_mem[0] = {old[31:16], 16'hBBBB};
        last_rd = 32'h0;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'd1024, 32'h0);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
        repeat (6) @(posedge clk); #1;
        begin
            exp_t ew, er;
            ew.lat = 0; ew.rd = last_rd; ew.wm = '0; ew.om = '0; ew.dm = '0;
            ref_mem[key_of(32'd1060)] = 32'h0BAD_BEEF;
            er = ew; er.rd = 32'h0BAD_BEEF;
            expq.push_back(ew);
            expq.push_back(er);
            last_rd = 32'h0BAD_BEEF;
            bus.wr_en = 1'b1; bus.addr = 32'd1060; bus.wr_data = 32'h0BAD_BEEF;
            @(negedge clk);
            chk("posted_ready_c0", bus.ready, 1'b1);
            @(posedge clk); #1;
            bus.wr_en = 1'b0; bus.rd_en = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                chk("posted_ready_cn", bus.ready, (c == 10));
            end
            @(posedge clk); #1;
            bus.rd_en = 1'b0;
        end
`endif

        for (int n = 0; n < 80; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a + 32'd4 * 32'd131072;
            if (r < 4)      issue(1'b1, 1'b0, a, $urandom);
            else if (r < 8) issue(1'b0, 1'b1, a, $urandom);
            else            issue(1'b1, 1'b1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        foreach (ref_mem[k]) begin
            chk("final_lo", sram[2 * k], ref_mem[k][15:0]);
            chk("final_hi", sram[2 * k + 1], ref_mem[k][31:16]);
        end
        chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
